fv_sb_wolper_src: RTL and testbench

Formal stimulus source and ordering checker for in-order push/pop datapaths using the Wolper data-independence technique. The block drives the DUT push interface with a coloured stream: zeros, a single `1`, more zeros, a single `2`, then zeros only. It watches the DUT pop interface for that colour order and flags loss, duplication, reordering, corruption and spontaneous data. It is the transmitter-side companion of the counter-based in-order scoreboard, and is bound in formal testbenches in place of free push inputs.

---
 rtl/fv_sb_pkg.sv | 10 +
 rtl/fv_wolper_chk.sv | 59 +++++
 rtl/fv_sb_wolper_src.sv | 85 ++++++++
 tb/tb_fv_sb_wolper_src.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fv_sb_pkg.sv
// fv_sb_pkg: shared types and colour constants for the Wolper source/checker pair.
//   gen_state_e : generator progress through the coloured stream
//   chk_state_e : checker progress through the observed colour order
package fv_sb_pkg;
    typedef enum logic [1:0] {G_PRE = 2'd0, G_MID = 2'd1, G_POST = 2'd2} gen_state_e;
    typedef enum logic [1:0] {C_WAIT1 = 2'd0, C_WAIT2 = 2'd1, C_DONE = 2'd2} chk_state_e;
    localparam int COL_ZERO = 0;
    localparam int COL_ONE  = 1;
    localparam int COL_TWO  = 2;
endpackage

// File: rtl/fv_wolper_chk.sv
// fv_wolper_chk: pop-side colour order checker with in-flight counter and sticky error.
//   clk, rstn          : clock, asynchronous active-low reset
//   i_push             : push handshake completed this cycle
//   i_push_data        : word accepted by the push
//   i_gen_state        : generator state (which colours were already accepted)
//   i_pop_valid/_data  : DUT pop event and word
//   o_cntr             : words accepted and not yet popped
//   o_chk_state        : checker FSM state
//   o_err              : sticky violation flag
module fv_wolper_chk
    import fv_sb_pkg::*;
#(
    parameter int DWIDTH    = 4,
    parameter int MAX_TRANS = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           i_push,
    input  logic [DWIDTH-1:0]              i_push_data,
    input  gen_state_e                     i_gen_state,
    input  logic                           i_pop_valid,
    input  logic [DWIDTH-1:0]              i_pop_data,
    output logic [$clog2(MAX_TRANS):0]     o_cntr,
    output chk_state_e                     o_chk_state,
    output logic                           o_err
);
    localparam int CW = $clog2(MAX_TRANS) + 1;
    logic [CW-1:0] r_cntr;
    chk_state_e    r_chk;
    logic          r_err;
    logic          w_acc1, w_acc2, w_c1, w_c2, w_under, w_bad;
    // A colour counts as accepted once the generator moved past it, or when
    // it is being pushed this very cycle (zero-latency DUT).
    assign w_acc1  = i_gen_state != G_PRE || (i_push && i_push_data == DWIDTH'(COL_ONE));
    assign w_acc2  = i_gen_state == G_POST || (i_push && i_push_data == DWIDTH'(COL_TWO));
    assign w_c1    = i_pop_valid && i_pop_data == DWIDTH'(COL_ONE);
    assign w_c2    = i_pop_valid && i_pop_data == DWIDTH'(COL_TWO);
    assign w_under = i_pop_valid && r_cntr == '0 && !i_push;
    assign w_bad   = (i_pop_valid && i_pop_data > DWIDTH'(COL_TWO))
                   || (w_c1 && (!w_acc1 || r_chk != C_WAIT1))
                   || (w_c2 && (!w_acc2 || r_chk != C_WAIT2))
                   || w_under;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cntr <= '0;
            r_chk  <= C_WAIT1;
            r_err  <= 1'b0;
        end else begin
            if (w_c1 && r_chk == C_WAIT1) r_chk <= C_WAIT2;
            if (w_c2 && r_chk == C_WAIT2) r_chk <= C_DONE;
            // On underflow the counter holds at zero instead of wrapping.
            if (!w_under) r_cntr <= r_cntr + CW'(i_push) - CW'(i_pop_valid);
            r_err <= r_err | w_bad;
        end
    end
    assign o_cntr      = r_cntr;
    assign o_chk_state = r_chk;
    assign o_err       = r_err;
endmodule

// File: rtl/fv_sb_wolper_src.sv
// fv_sb_wolper_src: Wolper coloured-stream push source plus in-order pop checker.
//   clk, rstn          : clock, asynchronous active-low reset
//   i_req, i_pick      : symbolic offer request / colour choice
//   i_push_ready       : DUT accepts the offered word
//   o_push_valid/_data : offered word (0, 1 or 2), held until accepted
//   i_pop_valid/_data  : DUT output stream
//   o_cntr             : words in flight (debug)
//   o_gen_state        : generator FSM state (debug)
//   o_chk_state        : checker FSM state (debug)
//   o_err              : sticky violation flag
module fv_sb_wolper_src
    import fv_sb_pkg::*;
#(
    parameter int DWIDTH    = 4,
    parameter int MAX_TRANS = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_req,
    input  logic                       i_pick,
    input  logic                       i_push_ready,
    output logic                       o_push_valid,
    output logic [DWIDTH-1:0]          o_push_data,
    input  logic                       i_pop_valid,
    input  logic [DWIDTH-1:0]          i_pop_data,
    output logic [$clog2(MAX_TRANS):0] o_cntr,
    output logic [1:0]                 o_gen_state,
    output logic [1:0]                 o_chk_state,
    output logic                       o_err
);
    gen_state_e        r_gen, w_gen_next;
    chk_state_e        w_chk;
    logic              r_push_valid, w_push;
    logic [DWIDTH-1:0] r_push_data, w_offer;
    assign w_push = r_push_valid && i_push_ready;
    always_comb begin
        w_gen_next = r_gen;
        if (w_push && r_push_data == DWIDTH'(COL_ONE)) w_gen_next = G_MID;
        if (w_push && r_push_data == DWIDTH'(COL_TWO)) w_gen_next = G_POST;
    end
    // The next offer is coloured from the post-push state so a back-to-back
    // offer after accepting 1 can already carry 2, never a second 1.
    assign w_offer = !i_pick ? DWIDTH'(COL_ZERO)
                   : w_gen_next == G_PRE ? DWIDTH'(COL_ONE)
                   : w_gen_next == G_MID ? DWIDTH'(COL_TWO) : DWIDTH'(COL_ZERO);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gen        <= G_PRE;
            r_push_valid <= 1'b0;
            r_push_data  <= '0;
        end else begin
            r_gen <= w_gen_next;
            if (!r_push_valid || w_push) begin
                r_push_valid <= i_req;
                r_push_data  <= i_req ? w_offer : '0;
            end
        end
    end
    fv_wolper_chk #(.DWIDTH(DWIDTH), .MAX_TRANS(MAX_TRANS)) u_chk (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (w_push),
        .i_push_data (r_push_data),
        .i_gen_state (r_gen),
        .i_pop_valid (i_pop_valid),
        .i_pop_data  (i_pop_data),
        .o_cntr      (o_cntr),
        .o_chk_state (w_chk),
        .o_err       (o_err)
    );
    assign o_push_valid = r_push_valid;
    assign o_push_data  = r_push_data;
    assign o_gen_state  = r_gen;
    assign o_chk_state  = w_chk;
`ifdef FORMAL
    a_no_err: assert property (@(posedge clk) disable iff (!rstn) !o_err);
    a_hold:   assert property (@(posedge clk) disable iff (!rstn)
                  r_push_valid && !i_push_ready |=> r_push_valid && $stable(r_push_data));
    a_one:    assert property (@(posedge clk) disable iff (!rstn)
                  w_push && r_push_data == DWIDTH'(COL_ONE) |-> s_eventually w_chk != C_WAIT1);
    a_two:    assert property (@(posedge clk) disable iff (!rstn)
                  w_push && r_push_data == DWIDTH'(COL_TWO) |-> s_eventually w_chk == C_DONE);
    a_cntr:   assert property (@(posedge clk) disable iff (!rstn) o_cntr <= MAX_TRANS);
`endif
endmodule

// File: tb/tb_fv_sb_wolper_src.sv
// tb_fv_sb_wolper_src: directed self-checking bench for fv_sb_wolper_src.
module tb_fv_sb_wolper_src;
    logic       clk = 1'b0;
    logic       rstn;
    logic       req, pick, push_ready, pop_valid;
    logic [3:0] pop_data;
    logic       push_valid, err;
    logic [3:0] push_data;
    logic [4:0] cntr;
    logic [1:0] gen_state, chk_state;
    int         checks = 0;
    int         errors = 0;

    fv_sb_wolper_src #(.DWIDTH(4), .MAX_TRANS(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_req        (req),
        .i_pick       (pick),
        .i_push_ready (push_ready),
        .o_push_valid (push_valid),
        .o_push_data  (push_data),
        .i_pop_valid  (pop_valid),
        .i_pop_data   (pop_data),
        .o_cntr       (cntr),
        .o_gen_state  (gen_state),
        .o_chk_state  (chk_state),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        {req, pick, push_ready, pop_valid} = '0;
        pop_data = '0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, int'(push_valid), 0);
        chk({tag, "_data"},  int'(push_data), 0);
        chk({tag, "_cntr"},  int'(cntr), 0);
        chk({tag, "_gen"},   int'(gen_state), 0);
        chk({tag, "_chk"},   int'(chk_state), 0);
        chk({tag, "_err"},   int'(err), 0);
    endtask

    initial begin
        // reset values
        do_reset();
        chk_reset("rst");

        // zeros stream: one-cycle offer latency, counter climbs by one per cycle
        req = 1; pick = 0; push_ready = 1;
        tick();
        chk("t1_valid", int'(push_valid), 1);
        chk("t1_data", int'(push_data), 0);
        chk("t1_cntr0", int'(cntr), 0);
        tick();
        chk("t1_cntr1", int'(cntr), 1);
        tick();
        chk("t1_cntr2", int'(cntr), 2);
        tick();
        chk("t1_cntr3", int'(cntr), 3);
        // simultaneous push and pop at cntr=3
        req = 0; pop_valid = 1; pop_data = 0;
        tick();
        chk("t6_cntr_same", int'(cntr), 3);
        chk("t6_valid_drop", int'(push_valid), 0);
        tick(3);
        pop_valid = 0;
        chk("t6_cntr_drain", int'(cntr), 0);
        chk("t6_err", int'(err), 0);

        // 0,1,0,2 pushed and popped in order
        do_reset();
        req = 1; pick = 0; push_ready = 1;
        tick();
        pick = 1;
        tick();
        chk("t2_data1", int'(push_data), 1);
        pick = 0;
        tick();
        chk("t2_gen_mid", int'(gen_state), 1);
        pick = 1;
        tick();
        chk("t2_data2", int'(push_data), 2);
        req = 0; pick = 0;
        tick();
        chk("t2_gen_post", int'(gen_state), 2);
        chk("t2_cntr4", int'(cntr), 4);
        pop_valid = 1; pop_data = 0;
        tick();
        pop_data = 1;
        tick();
        chk("t2_wait2", int'(chk_state), 1);
        pop_data = 0;
        tick();
        pop_data = 2;
        tick();
        pop_valid = 0;
        chk("t2_done", int'(chk_state), 2);
        chk("t2_err", int'(err), 0);
        chk("t2_cntr0", int'(cntr), 0);

        // push 1 then 2, pop 2 then 1: reorder
        do_reset();
        req = 1; pick = 1; push_ready = 1;
        tick(2);
        req = 0; pick = 0;
        tick();
        chk("t3_cntr", int'(cntr), 2);
        pop_valid = 1; pop_data = 2;
        tick();
        chk("t3_err", int'(err), 1);
        pop_data = 1;
        tick();
        pop_valid = 0;
        tick();
        chk("t3_err_sticky", int'(err), 1);

        // back-pressure: offered 1 held for 5 cycles
        do_reset();
        req = 1; pick = 1; push_ready = 0;
        tick();
        req = 0; pick = 0;
        tick(5);
        chk("t4_valid", int'(push_valid), 1);
        chk("t4_data", int'(push_data), 1);
        chk("t4_gen", int'(gen_state), 0);
        chk("t4_cntr", int'(cntr), 0);
        push_ready = 1;
        tick();
        chk("t4_gen_mid", int'(gen_state), 1);
        chk("t4_cntr1", int'(cntr), 1);

        // underflow
        do_reset();
        pop_valid = 1; pop_data = 0;
        tick();
        pop_valid = 0;
        chk("t5_under_err", int'(err), 1);
        chk("t5_under_cntr", int'(cntr), 0);

        // corruption with a word in flight
        do_reset();
        req = 1; push_ready = 1;
        tick();
        req = 0;
        tick();
        chk("t5_pre_err", int'(err), 0);
        pop_valid = 1; pop_data = 3;
        tick();
        pop_valid = 0;
        chk("t5_corrupt_err", int'(err), 1);

        // spontaneous 1 (only a zero was accepted)
        do_reset();
        req = 1; push_ready = 1;
        tick();
        req = 0;
        tick();
        pop_valid = 1; pop_data = 1;
        tick();
        pop_valid = 0;
        chk("t7_spont_err", int'(err), 1);

        // zero-latency: 1 pushed and popped in the same cycle
        do_reset();
        req = 1; pick = 1; push_ready = 1;
        tick();
        req = 0; pick = 0; pop_valid = 1; pop_data = 1;
        tick();
        pop_valid = 0;
        chk("t8_zl_err", int'(err), 0);
        chk("t8_zl_chk", int'(chk_state), 1);
        chk("t8_zl_cntr", int'(cntr), 0);

        // asynchronous reset mid-handshake with error set
        req = 1; push_ready = 0; pop_valid = 1; pop_data = 3;
        tick();
        pop_valid = 0;
        chk("t9_pre_valid", int'(push_valid), 1);
        chk("t9_pre_err", int'(err), 1);
        #3;
        rstn = 1'b0;
        #1;
        chk_reset("t9_async");
        req = 0;
        tick();
        rstn = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
